// File: rtl/led_frame_loader_if.sv
// Byte-stream input handshake and frame-RAM write port of the LED cube frame loader.
interface led_frame_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/led_frame_loader.sv
// LED cube frame loader: parses SYNC, IDX, 64-byte payload packets into frame RAM writes.
// Defining LED_LOADER_CHECKSUM_EN adds a trailing checksum byte and the err_checksum report.
module led_frame_loader #(
    parameter int          FRAME_BYTES = 64,
    parameter int          MAX_FRAMES  = 150,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [19:0] TIMEOUT_CYC = 20'hFFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    led_frame_loader_if.slave  bus,
    output logic               frame_loaded,
    output logic [7:0]         loaded_idx,
    output logic               err_index,
    output logic               err_checksum,
    output logic               err_timeout,
    output logic               busy
);
    localparam logic [5:0]  LAST_BYTE = 6'(FRAME_BYTES - 1);
    localparam logic [8:0]  MAX_IDX   = 9'(MAX_FRAMES);
    localparam logic [19:0] GAP_LAST  = TIMEOUT_CYC - 20'd1;

    typedef enum logic [2:0] {S_IDLE, S_IDX, S_PAYLOAD, S_CSUM, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        drop_q, drop_d;
    logic [19:0] gap_q, gap_d;
    logic        wr_en_q, wr_en_d;
    logic [13:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        loaded_q, loaded_d;
    logic [7:0]  loaded_idx_q, loaded_idx_d;
    logic        err_idx_q, err_idx_d;
    logic        err_to_q, err_to_d;
    logic        accept;
`ifdef LED_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        err_csum_q, err_csum_d;
`endif

    // abort wins over a byte offered in the same cycle: that byte is discarded
    assign accept = bus.in_valid && bus.in_ready && !abort;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        drop_d       = drop_q;
        gap_d        = gap_q + 20'd1;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        loaded_d     = 1'b0;
        loaded_idx_d = loaded_idx_q;
        err_idx_d    = 1'b0;
        err_to_d     = 1'b0;
`ifdef LED_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        err_csum_d   = 1'b0;
`endif
        if (state_q == S_IDLE || accept) gap_d = '0;

        case (state_q)
            S_IDLE: begin
                if (accept && bus.in_data == SYNC_BYTE) state_d = S_IDX;
            end
            S_IDX: begin
                if (accept) begin
                    idx_d     = bus.in_data;
                    cnt_d     = '0;
                    drop_d    = ({1'b0, bus.in_data} >= MAX_IDX);
                    err_idx_d = ({1'b0, bus.in_data} >= MAX_IDX);
`ifdef LED_LOADER_CHECKSUM_EN
                    sum_d     = bus.in_data;
`endif
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (!drop_q) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {idx_q, cnt_q};
                        wr_data_d = bus.in_data;
                    end
                    cnt_d = cnt_q + 6'd1;
`ifdef LED_LOADER_CHECKSUM_EN
                    sum_d = sum_q + bus.in_data;
                    if (cnt_q == LAST_BYTE) state_d = S_CSUM;
`else
                    if (cnt_q == LAST_BYTE) begin
                        state_d = S_DONE;
                        if (!drop_q) begin
                            loaded_d     = 1'b1;
                            loaded_idx_d = idx_q;
                        end
                    end
`endif
                end
            end
`ifdef LED_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (bus.in_data == sum_q) begin
                        state_d = S_DONE;
                        if (!drop_q) begin
                            loaded_d     = 1'b1;
                            loaded_idx_d = idx_q;
                        end
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // an accepted byte in the same cycle keeps the packet alive
        if (state_q != S_IDLE && state_q != S_DONE && !accept && gap_q == GAP_LAST) begin
            state_d  = S_IDLE;
            err_to_d = 1'b1;
        end

        if (abort) begin
            state_d  = S_IDLE;
            err_to_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            drop_q       <= 1'b0;
            gap_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            loaded_q     <= 1'b0;
            loaded_idx_q <= '0;
            err_idx_q    <= 1'b0;
            err_to_q     <= 1'b0;
`ifdef LED_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            err_csum_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            drop_q       <= drop_d;
            gap_q        <= gap_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            loaded_q     <= loaded_d;
            loaded_idx_q <= loaded_idx_d;
            err_idx_q    <= err_idx_d;
            err_to_q     <= err_to_d;
`ifdef LED_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            err_csum_q   <= err_csum_d;
`endif
        end
    end

    assign bus.in_ready = (state_q != S_DONE);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign frame_loaded = loaded_q;
    assign loaded_idx   = loaded_idx_q;
    assign err_index    = err_idx_q;
    assign err_timeout  = err_to_q;
    assign busy         = (state_q != S_IDLE);
`ifdef LED_LOADER_CHECKSUM_EN
    assign err_checksum = err_csum_q;
`else
    assign err_checksum = 1'b0;
`endif
endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader: packet loads, junk, bad index, timeout, abort, reset.
module tb_led_frame_loader;
    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       frame_loaded, err_index, err_checksum, err_timeout, busy;
    logic [7:0] loaded_idx;

    led_frame_loader_if ifc();

    led_frame_loader #(.TIMEOUT_CYC(20'(TO))) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .abort        (abort),
        .bus          (ifc),
        .frame_loaded (frame_loaded),
        .loaded_idx   (loaded_idx),
        .err_index    (err_index),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miscompares = 0;
    int n_wr = 0, n_ld = 0, n_ei = 0, n_ec = 0, n_et = 0;
    int w0, l0, ei0, ec0, et0;
    logic [7:0] mem [0:16383];

    // frame RAM model and pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (ifc.wr_en) begin
            n_wr++;
            mem[ifc.wr_addr] = ifc.wr_data;
        end
        if (frame_loaded) n_ld++;
        if (err_index)    n_ei++;
        if (err_checksum) n_ec++;
        if (err_timeout)  n_et++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        ifc.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int g = 0;
        while (!ifc.in_ready && g < 8) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!ifc.in_ready) chk("in_ready_wait", {31'b0, ifc.in_ready}, 32'd1);
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    // full packet, payload byte i = base + step*i; returns at the DONE cycle
    task automatic send_frame(input logic [7:0] idx, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] s;
        s = idx;
        send(8'hA5);
        send(idx);
        for (int i = 0; i < 64; i++) begin
            send(base + step * 8'(i));
            s = s + base + step * 8'(i);
        end
`ifdef LED_LOADER_CHECKSUM_EN
        send(s);
`endif
    endtask

    task automatic snap();
        w0 = n_wr; l0 = n_ld; ei0 = n_ei; ec0 = n_ec; et0 = n_et;
    endtask

    initial begin
        logic [7:0] s;
        int bad;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;

        // reset state
        idle(3);
        chk("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
        chk("rst_wr_en", {31'b0, ifc.wr_en}, 32'd0);
        chk("rst_wr_addr", {18'b0, ifc.wr_addr}, 32'd0);
        chk("rst_wr_data", {24'b0, ifc.wr_data}, 32'd0);
        chk("rst_loaded_idx", {24'b0, loaded_idx}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pulses", {27'b0, frame_loaded, err_index, err_checksum, err_timeout, 1'b0}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: idx 5, payload 00..3F
        snap();
        s = 8'h05;
        send(8'hA5);
        chk("t1_busy_after_sync", {31'b0, busy}, 32'd1);
        send(8'h05);
        send(8'h00);
        chk("t1_first_wr_en", {31'b0, ifc.wr_en}, 32'd1);
        chk("t1_first_wr_addr", {18'b0, ifc.wr_addr}, 32'h140);
        chk("t1_first_wr_data", {24'b0, ifc.wr_data}, 32'h00);
        for (int i = 1; i < 64; i++) begin
            send(8'(i));
            s = s + 8'(i);
        end
`ifdef LED_LOADER_CHECKSUM_EN
        chk("t1_csum_value", {24'b0, s}, 32'hE5);
        send(s);
`endif
        chk("t1_frame_loaded", {31'b0, frame_loaded}, 32'd1);
        chk("t1_loaded_idx", {24'b0, loaded_idx}, 32'h05);
        chk("t1_done_in_ready", {31'b0, ifc.in_ready}, 32'd0);
        idle(1);
        chk("t1_pulse_width", {31'b0, frame_loaded}, 32'd0);
        chk("t1_idle_busy", {31'b0, busy}, 32'd0);
        chk("t1_writes", 32'(n_wr - w0), 32'd64);
        chk("t1_loads", 32'(n_ld - l0), 32'd1);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[14'h140 + 14'(i)] !== 8'(i)) bad++;
        chk("t1_mem_bad_bytes", 32'(bad), 32'd0);
        chk("t1_mem_last", {24'b0, mem[14'h17F]}, 32'h3F);

        // 2: junk then idx 0, payload all AA
        snap();
        send(8'h00);
        send(8'hFF);
        send(8'h12);
        chk("t2_junk_busy", {31'b0, busy}, 32'd0);
        send_frame(8'h00, 8'hAA, 8'h00);
        chk("t2_frame_loaded", {31'b0, frame_loaded}, 32'd1);
        chk("t2_loaded_idx", {24'b0, loaded_idx}, 32'h00);
        idle(1);
        chk("t2_writes", 32'(n_wr - w0), 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[14'(i)] !== 8'hAA) bad++;
        chk("t2_mem_bad_bytes", 32'(bad), 32'd0);

        // 3: index 150 rejected, payload consumed without writes
        snap();
        send(8'hA5);
        send(8'h96);
        chk("t3_err_index", {31'b0, err_index}, 32'd1);
        idle(1);
        chk("t3_err_index_width", {31'b0, err_index}, 32'd0);
        for (int i = 0; i < 64; i++) send(8'h11);
`ifdef LED_LOADER_CHECKSUM_EN
        send(8'h96 + 8'h11 * 8'd64);
`endif
        idle(2);
        chk("t3_writes", 32'(n_wr - w0), 32'd0);
        chk("t3_loads", 32'(n_ld - l0), 32'd0);
        chk("t3_loaded_idx_held", {24'b0, loaded_idx}, 32'h00);
        chk("t3_busy", {31'b0, busy}, 32'd0);

        // 3b: last valid index 149
        snap();
        send_frame(8'h95, 8'h40, 8'h01);
        chk("t3b_loaded_idx", {24'b0, loaded_idx}, 32'h95);
        idle(1);
        chk("t3b_err_index", 32'(n_ei - ei0), 32'd0);
        chk("t3b_writes", 32'(n_wr - w0), 32'd64);
        chk("t3b_mem_last", {24'b0, mem[14'h257F]}, 32'h7F);

`ifdef LED_LOADER_CHECKSUM_EN
        // 4: wrong checksum
        snap();
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 64; i++) send(8'h01);
        send(8'h00);
        chk("t4_err_checksum", {31'b0, err_checksum}, 32'd1);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        idle(1);
        chk("t4_writes", 32'(n_wr - w0), 32'd64);
        chk("t4_loads", 32'(n_ld - l0), 32'd0);
`endif

        // 5: inter-byte timeout, then recovery
        snap();
        send(8'hA5);
        send(8'h02);
        for (int i = 0; i < 10; i++) send(8'(i));
        idle(TO - 1);
        chk("t5_busy_before_to", {31'b0, busy}, 32'd1);
        chk("t5_no_early_to", {31'b0, err_timeout}, 32'd0);
        idle(1);
        chk("t5_err_timeout", {31'b0, err_timeout}, 32'd1);
        chk("t5_busy_after_to", {31'b0, busy}, 32'd0);
        chk("t5_writes", 32'(n_wr - w0), 32'd10);
        chk("t5_partial_kept", {24'b0, mem[14'h089]}, 32'h09);
        snap();
        send_frame(8'h07, 8'h10, 8'h03);
        chk("t5_reload_idx", {24'b0, loaded_idx}, 32'h07);
        idle(1);
        chk("t5_reload_writes", 32'(n_wr - w0), 32'd64);
        chk("t5_reload_mem", {24'b0, mem[14'h1FF]}, 32'h10 + 32'd3 * 32'd63 & 32'hFF);

        // 6a: abort while payload byte 30 is offered
        snap();
        send(8'hA5);
        send(8'h03);
        for (int i = 0; i < 30; i++) send(8'(i));
        abort = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'd30;
        @(posedge clk);
        #1;
        abort = 1'b0;
        ifc.in_valid = 1'b0;
        chk("t6a_busy", {31'b0, busy}, 32'd0);
        chk("t6a_wr_en", {31'b0, ifc.wr_en}, 32'd0);
        idle(4);
        chk("t6a_writes", 32'(n_wr - w0), 32'd30);
        chk("t6a_pulses", 32'((n_ld - l0) + (n_ei - ei0) + (n_ec - ec0) + (n_et - et0)), 32'd0);

        // 6b: reset while payload byte 40 is offered
        snap();
        send(8'hA5);
        send(8'h04);
        for (int i = 0; i < 40; i++) send(8'(i));
        rst_n = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'd40;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        chk("t6b_busy", {31'b0, busy}, 32'd0);
        chk("t6b_wr_en", {31'b0, ifc.wr_en}, 32'd0);
        chk("t6b_loaded_idx", {24'b0, loaded_idx}, 32'h00);
        rst_n = 1'b1;
        idle(4);
        chk("t6b_writes", 32'(n_wr - w0), 32'd40);
        chk("t6b_pulses", 32'((n_ld - l0) + (n_ei - ei0) + (n_ec - ec0) + (n_et - et0)), 32'd0);
        chk("t6b_in_ready", {31'b0, ifc.in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
